seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have local parameter SHW, equal to clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 The block SHALL have ports op1 and op2, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port shamt, input, SHW bits: the shift amount.
REQ-009 The block SHALL have port ALUsignal, input, 4 bits: the operation select.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking new results.
REQ-011 The block SHALL have port result, output, WIDTH bits: the primary result.
REQ-012 The block SHALL have port hi, output, WIDTH bits: the MULU high half or DIVU remainder.
REQ-013 The block SHALL have port ZF, output, 1 bit: set when result is zero.
REQ-014 The block SHALL have port OF, output, 1 bit: signed overflow, driven for ADD and SUB only.
REQ-015 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.

Function
REQ-016 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL equal ~busy; in_valid while busy SHALL be ignored, with no queuing.
REQ-017 Encoding SHALL be: 0 ADD, 1 AND, 2 NOR, 3 OR, 4 SLT (signed), 5 SLTU, 6 SLL, 7 SRL, 8 SUB, 9 SRA, 10 XOR, 11 MULU, 12 DIVU; codes 13-15 SHALL produce result=0, hi=0, OF=0, ZF=1.
REQ-018 ADD and SUB SHALL be modulo 2^WIDTH; OF SHALL be the two's-complement overflow of the operation; SLT and SLTU SHALL give 1 or 0, zero-extended.
REQ-019 Shift ops SHALL shift op2 by shamt; SRA SHALL replicate op2[WIDTH-1].
REQ-020 Single-cycle ops (0-10, 13-15) SHALL register result/hi/ZF/OF on the accept edge, with out_valid=1 for exactly the following cycle; hi=0 and, except for ADD/SUB, OF=0.
REQ-021 The FSM SHALL have states IDLE, MUL, and DIV; accepting MULU SHALL go IDLE->MUL and accepting DIVU SHALL go IDLE->DIV, with a bit counter loaded to WIDTH.
REQ-022 MUL SHALL perform unsigned shift-add, one bit per cycle; DIV SHALL perform unsigned restoring division, one quotient bit per cycle.
REQ-023 busy SHALL be 1 in MUL and DIV; operands SHALL be latched at accept, so later changes to op1/op2 have no effect.
REQ-024 MULU/DIVU SHALL update outputs on the edge WIDTH cycles after accept, pulse out_valid for one cycle, and return to IDLE; in_ready SHALL be 1 in that out_valid cycle, allowing back-to-back accepts.
REQ-025 MULU SHALL produce the 2*WIDTH-bit product split as {hi, result}; DIVU SHALL produce result = quotient and hi = remainder; OF SHALL be 0 for both.
REQ-026 DIVU with op2=0 SHALL complete as a single-cycle op with result = all ones, hi = op1, and no entry to DIV.
REQ-027 ZF SHALL reflect the value of result registered in the same edge.
REQ-028 result/hi/ZF/OF SHALL hold their last values until the next completion.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE, counter=0, result=0, hi=0, ZF=0, OF=0, out_valid=0, busy=0, in_ready=1.
REQ-030 Assertion of rst mid-MUL/DIV SHALL abort the operation immediately; no out_valid SHALL be produced for it.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 ADD of 0x7FFFFFFF and 0x00000001 -> next cycle: result=0x80000000, OF=1, ZF=0, out_valid=1 for one cycle.
REQ-033 SUB of 5 and 5 -> result=0, ZF=1, OF=0; SLT of 0xFFFFFFFF and 1 -> 1; SLTU of the same operands -> 0.
REQ-034 SRA of op2=0x80000000 with shamt=4 -> 0xF8000000; SRL of the same -> 0x08000000.
REQ-035 MULU of 0xFFFFFFFF and 0xFFFFFFFF -> busy=1 and in_ready=0 for 32 cycles, then hi=0xFFFFFFFE, result=0x00000001, a single out_valid; an ADD held on in_valid during busy is not taken until in_ready=1.
REQ-036 DIVU of 100 and 7 -> after 32 cycles result=14, hi=2; DIVU of 9 and 0 -> next cycle result=0xFFFFFFFF, hi=9, busy never set.
REQ-037 rst pulsed in cycle 10 of a DIVU -> all outputs 0, in_ready=1, no out_valid; a fresh ADD after release completes normally.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : ALU with single-cycle logic/arith/shift ops and multi-cycle
//            unsigned shift-add multiply and restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       ALUsignal,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             ZF,
    output logic             OF,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_and  = 4'd1;
    localparam logic [3:0] c_op_nor  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_slt  = 4'd4;
    localparam logic [3:0] c_op_sltu = 4'd5;
    localparam logic [3:0] c_op_sll  = 4'd6;
    localparam logic [3:0] c_op_srl  = 4'd7;
    localparam logic [3:0] c_op_sub  = 4'd8;
    localparam logic [3:0] c_op_sra  = 4'd9;
    localparam logic [3:0] c_op_xor  = 4'd10;
    localparam logic [3:0] c_op_mulu = 4'd11;
    localparam logic [3:0] c_op_divu = 4'd12;

    localparam logic [SHW:0] c_cnt_init = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] c_cnt_last = (SHW+1)'(1);

    logic [1:0]       r_state;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_a;      // product high half / partial remainder
    logic [WIDTH-1:0] r_b;      // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] r_m;      // multiplicand / divisor
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zf;
    logic             r_of;
    logic             r_out_valid;

    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_of;
    logic [WIDTH:0]   w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    assign busy      = (r_state != IDLE);
    assign in_ready  = ~busy;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign hi        = r_hi;
    assign ZF        = r_zf;
    assign OF        = r_of;

    assign w_sum  = op1 + op2;
    assign w_diff = op1 - op2;

    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_of  = 1'b0;
        case (ALUsignal)
            c_op_add: begin
                w_res = w_sum;
                w_of  = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            c_op_and:  w_res = op1 & op2;
            c_op_nor:  w_res = ~(op1 | op2);
            c_op_or:   w_res = op1 | op2;
            c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            c_op_sll:  w_res = op2 << shamt;
            c_op_srl:  w_res = op2 >> shamt;
            c_op_sub: begin
                w_res = w_diff;
                w_of  = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            c_op_sra:  w_res = $signed(op2) >>> shamt;
            c_op_xor:  w_res = op1 ^ op2;
            // Only reached here for the divide-by-zero shortcut.
            c_op_divu: begin
                w_res = '1;
                w_hi  = op1;
            end
            default: begin
                w_res = '0;
                w_hi  = '0;
            end
        endcase
    end

    assign w_mul_sum  = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_b[WIDTH-1:1]};

    assign w_div_shift = {r_a, r_b[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_m};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_b[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_result    <= '0;
            r_hi        <= '0;
            r_zf        <= 1'b0;
            r_of        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (ALUsignal == c_op_mulu) begin
                            r_state <= MUL;
                            r_cnt   <= c_cnt_init;
                            r_a     <= '0;
                            r_b     <= op2;
                            r_m     <= op1;
                        end else if (ALUsignal == c_op_divu && op2 != '0) begin
                            r_state <= DIV;
                            r_cnt   <= c_cnt_init;
                            r_a     <= '0;
                            r_b     <= op1;
                            r_m     <= op2;
                        end else begin
                            r_result    <= w_res;
                            r_hi        <= w_hi;
                            r_zf        <= (w_res == '0);
                            r_of        <= w_of;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    {r_a, r_b} <= w_mul_next;
                    r_cnt      <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_result    <= w_mul_next[WIDTH-1:0];
                        r_hi        <= w_mul_next[2*WIDTH-1:WIDTH];
                        r_zf        <= (w_mul_next[WIDTH-1:0] == '0);
                        r_of        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                DIV: begin
                    r_a   <= w_div_rem;
                    r_b   <= w_div_quo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_result    <= w_div_quo;
                        r_hi        <= w_div_rem;
                        r_zf        <= (w_div_quo == '0);
                        r_of        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Randomized self-checking bench for seq_alu against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic [SHW-1:0] shamt;
    logic [3:0]     ALUsignal;
    logic           out_valid;
    logic [W-1:0]   result;
    logic [W-1:0]   hi;
    logic           ZF;
    logic           OF;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .shamt     (shamt),
        .ALUsignal (ALUsignal),
        .out_valid (out_valid),
        .result    (result),
        .hi        (hi),
        .ZF        (ZF),
        .OF        (OF),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: results from plain arithmetic on the operand values.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh, output logic [W-1:0] er,
                         output logic [W-1:0] eh, output logic eo, output logic em);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        er = '0; eh = '0; eo = 1'b0; em = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; er = W'(s); eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: er = a & b;
            4'd2: er = ~(a | b);
            4'd3: er = a | b;
            4'd4: er = (sa < sb) ? 1 : 0;
            4'd5: er = (a < b) ? 1 : 0;
            4'd6: er = W'(64'(b) * (64'd1 << sh));
            4'd7: er = W'(64'(b) / (64'd1 << sh));
            4'd8: begin s = sa - sb; er = W'(s); eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd9: er = W'(sb >>> sh);
            4'd10: er = a ^ b;
            4'd11: begin p = 64'(a) * 64'(b); er = p[31:0]; eh = p[63:32]; em = 1'b1; end
            4'd12: begin
                if (b == 0) begin er = '1; eh = a; end
                else begin er = a / b; eh = a % b; em = 1'b1; end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SHW-1:0] sh);
        logic [W-1:0] er, eh;
        logic eo, em;
        int lat;
        model(op, a, b, sh, er, eh, eo, em);
        ALUsignal = op; op1 = a; op2 = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; shamt = SHW'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            check("busy_during_op", busy, 1);
            check("in_ready_during_op", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, em ? W : 0);
        check("result", result, er);
        check("hi", hi, eh);
        check("ZF", ZF, er == 0);
        check("OF", OF, eo);
        check("in_ready_at_done", in_ready, 1);
        @(posedge clk); #1;
        check("out_valid_pulse", out_valid, 0);
        check("result_hold", result, er);
    endtask

    initial begin
        logic seen;
        int lat;
        logic [3:0] op;
        logic [W-1:0] a, b;

        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; shamt = '0; ALUsignal = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_ZF", ZF, 0);
        check("rst_OF", OF, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        run_op(4'd0, 32'h7FFFFFFF, 32'h00000001, 0);
        run_op(4'd8, 32'd5, 32'd5, 0);
        run_op(4'd4, 32'hFFFFFFFF, 32'd1, 0);
        run_op(4'd5, 32'hFFFFFFFF, 32'd1, 0);
        run_op(4'd9, 32'h0, 32'h80000000, 5'd4);
        run_op(4'd7, 32'h0, 32'h80000000, 5'd4);
        run_op(4'd8, 32'h80000000, 32'd1, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'd9, 32'd0, 0);
        run_op(4'd13, 32'h1234, 32'h5678, 0);

        // MULU with an ADD held on in_valid throughout the busy period
        ALUsignal = 4'd11; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        ALUsignal = 4'd0; op1 = 32'd3; op2 = 32'd4;
        lat = 0;
        while (!out_valid && lat < 100) begin
            check("held_busy", busy, 1);
            check("held_in_ready", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("held_mul_latency", lat, W);
        check("held_mul_hi", hi, 32'hFFFFFFFE);
        check("held_mul_result", result, 32'h00000001);
        check("held_in_ready_done", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held_add_valid", out_valid, 1);
        check("held_add_result", result, 32'd7);
        check("held_add_hi", hi, 0);
        @(posedge clk); #1;
        check("held_add_pulse", out_valid, 0);

        // Reset in the middle of a divide
        ALUsignal = 4'd12; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_result", result, 0);
        check("abort_hi", hi, 0);
        check("abort_ZF", ZF, 0);
        check("abort_OF", OF, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", seen, 0);
        run_op(4'd0, 32'd10, 32'd20, 0);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(op, a, b, SHW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
